// File: rtl/ccff_pkg.sv
// Shared types and constants for the ccff configuration-chain loader.
package ccff_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } ccff_ld_state_t;

    // Flip-flop count of the connection-block / IO-tile chain.
    localparam int unsigned CCFF_CHAIN_LEN_CBX = 30;

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in / serial-out word register; LSB leaves first, tracks bits left in the word.
module ccff_piso #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REM_W  = $clog2(DATA_W + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [REM_W-1:0]  rem_i,
    input  logic              shift_i,
    output logic              bit_o,
    output logic [REM_W-1:0]  rem_o
);

    logic [DATA_W-1:0] sr_q, sr_d;
    logic [REM_W-1:0]  rem_q, rem_d;

    // Load wins over shift so a prefetched word replaces the word whose last bit is leaving.
    always_comb begin
        sr_d  = sr_q;
        rem_d = rem_q;
        if (load_i) begin
            sr_d  = data_i;
            rem_d = rem_i;
        end else if (shift_i) begin
            sr_d = sr_q >> 1;
            if (rem_q != '0) begin
                rem_d = rem_q - REM_W'(1);
            end
        end
    end

    // Word and remaining-count registers.
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            sr_q  <= '0;
            rem_q <= '0;
        end else begin
            sr_q  <= sr_d;
            rem_q <= rem_d;
        end
    end

    assign bit_o = sr_q[0];
    assign rem_o = rem_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words onto the ccff chain head, gating the chain clock on word starvation.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = CCFF_CHAIN_LEN_CBX,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tail_ones
);

    localparam int unsigned REM_W = $clog2(DATA_W + 1);

    ccff_ld_state_t   state_q, state_d;
    logic [CNT_W-1:0] bits_sent_q, bits_sent_d;
    logic [CNT_W-1:0] tail_ones_q, tail_ones_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             head_q, head_d;
    logic             clk_en_q, clk_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             piso_load;
    logic             piso_shift;
    logic             piso_bit;
    logic [REM_W-1:0] piso_rem;
    logic [REM_W-1:0] load_rem;
    logic [REM_W-1:0] rem_next;
    logic [CNT_W-1:0] bits_left;

    assign accept = cfg_valid & cfg_ready_q;

    ccff_piso #(
        .DATA_W (DATA_W),
        .REM_W  (REM_W)
    ) u_piso (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .load_i     (piso_load),
        .data_i     (cfg_data),
        .rem_i      (load_rem),
        .shift_i    (piso_shift),
        .bit_o      (piso_bit),
        .rem_o      (piso_rem)
    );

    // Next-state, chain controls, tail counting and look-ahead ready.
    always_comb begin
        state_d     = state_q;
        bits_sent_d = bits_sent_q;
        tail_ones_d = tail_ones_q;
        head_d      = head_q;
        clk_en_d    = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_ready_d = 1'b0;
        piso_load   = 1'b0;
        piso_shift  = 1'b0;
        bits_left   = '0;
        load_rem    = '0;
        rem_next    = '0;

        // The chain shifts on this edge, so ccff_tail still shows the bit being pushed out.
        if (clk_en_q && ccff_tail && (tail_ones_q != {CNT_W{1'b1}})) begin
            tail_ones_d = tail_ones_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bits_sent_d = '0;
                    tail_ones_d = '0;
                    busy_d      = 1'b1;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (accept) begin
                    piso_load = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                piso_shift  = 1'b1;
                head_d      = piso_bit;
                clk_en_d    = 1'b1;
                bits_sent_d = bits_sent_q + CNT_W'(1);
                if (bits_sent_d >= CNT_W'(CHAIN_LEN)) begin
                    state_d = FINISH;
                end else if (piso_rem == REM_W'(1)) begin
                    // Prefetched word streams without a bubble; otherwise stall in FETCH.
                    if (accept) begin
                        piso_load = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FINISH: begin
                head_d  = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A word carries at most the bits the chain still needs; surplus upper bits are dropped.
        bits_left = CNT_W'(CHAIN_LEN) - bits_sent_d;
        if (bits_left < CNT_W'(DATA_W)) begin
            load_rem = REM_W'(bits_left);
        end else begin
            load_rem = REM_W'(DATA_W);
        end

        if (piso_load) begin
            rem_next = load_rem;
        end else if (piso_shift && (piso_rem != '0)) begin
            rem_next = piso_rem - REM_W'(1);
        end else begin
            rem_next = piso_rem;
        end

        // Ready is registered, so it is decided one cycle ahead from the next state.
        if (state_d == FETCH) begin
            cfg_ready_d = 1'b1;
        end else if ((state_d == SHIFT) && (rem_next == REM_W'(1)) &&
                     ((bits_sent_d + CNT_W'(1)) < CNT_W'(CHAIN_LEN))) begin
            cfg_ready_d = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge prog_clk) begin
        if (!prog_rst_n) begin
            state_q     <= IDLE;
            bits_sent_q <= '0;
            tail_ones_q <= '0;
            cfg_ready_q <= 1'b0;
            head_q      <= 1'b0;
            clk_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_sent_q <= bits_sent_d;
            tail_ones_q <= tail_ones_d;
            cfg_ready_q <= cfg_ready_d;
            head_q      <= head_d;
            clk_en_q    <= clk_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready   = cfg_ready_q;
    assign ccff_head   = head_q;
    assign ccff_clk_en = clk_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tail_ones   = tail_ones_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: table-driven loads, randomised loads against a bit-queue model,
// and a short-chain instance.
module tb_ccff_chain_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic        head;
    logic        en;
    logic        tail;
    logic        busy;
    logic        done;
    logic [15:0] tail_ones;

    logic        s5_start;
    logic [7:0]  s5_data;
    logic        s5_valid;
    logic        s5_ready;
    logic        s5_head;
    logic        s5_en;
    logic        s5_tail;
    logic        s5_busy;
    logic        s5_done;
    logic [15:0] s5_tail_ones;

    int n_vec;
    int n_err;

    ccff_chain_loader #(.CHAIN_LEN(30), .DATA_W(8), .CNT_W(16)) dut (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(start), .cfg_data(data),
        .cfg_valid(valid), .cfg_ready(ready), .ccff_head(head), .ccff_clk_en(en),
        .ccff_tail(tail), .busy(busy), .done(done), .tail_ones(tail_ones)
    );

    ccff_chain_loader #(.CHAIN_LEN(5), .DATA_W(8), .CNT_W(16)) dut5 (
        .prog_clk(clk), .prog_rst_n(rst_n), .start(s5_start), .cfg_data(s5_data),
        .cfg_valid(s5_valid), .cfg_ready(s5_ready), .ccff_head(s5_head), .ccff_clk_en(s5_en),
        .ccff_tail(s5_tail), .busy(s5_busy), .done(s5_done), .tail_ones(s5_tail_ones)
    );

    always #5 clk = ~clk;

    // Downstream 30-flop chain, clocked only when the loader enables it.
    logic [29:0] chain_m;
    logic [29:0] pre_val;
    logic        pre_req;
    always @(posedge clk) begin
        if (pre_req) chain_m <= pre_val;
        else if (en) chain_m <= {chain_m[28:0], head};
    end
    assign tail = chain_m[29];

    typedef struct {
        logic [3:0][7:0] words;
        int              gap;
        int              drop;
        bit              preload;
        logic [29:0]     pre;
        logic [29:0]     exp_head;
        int              exp_tail;
        int              abort_at;
        int              restart_at;
        int              idle_valid;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0][7:0] w, input int gap, input bit pl,
                                input logic [29:0] pre, input logic [29:0] eh, input int et,
                                input int ab, input int rs, input int iv);
        vec_t v;
        v.words = w; v.gap = gap; v.drop = 0; v.preload = pl; v.pre = pre;
        v.exp_head = eh; v.exp_tail = et; v.abort_at = ab; v.restart_at = rs; v.idle_valid = iv;
        return v;
    endfunction

    task automatic do_load(input vec_t v);
        int          nbits = 0;
        int          nhs = 0;
        int          ndone = 0;
        int          first_en = -1;
        int          last_en = -1;
        int          cyc = 0;
        int          gap_left = v.gap;
        bit          fin = 0;
        bit          rs_done = 0;
        logic        last_head = 1'b0;
        logic        prev_en = 1'b0;
        logic [29:0] got = '0;
        logic [29:0] exp_chain;
        logic [15:0] tail_at_done;

        if (v.preload) begin
            pre_val = v.pre; pre_req = 1'b1;
            @(negedge clk);
            pre_req = 1'b0;
        end
        for (int i = 0; i < v.idle_valid; i++) begin
            valid = 1'b1; data = 8'hEE;
            @(negedge clk);
            chk("idle_ready", 64'(ready), 64'(0));
            chk("idle_busy", 64'(busy), 64'(0));
        end
        valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (!fin && cyc < 300) begin
            if (en) begin
                if (nbits < 30) got[nbits] = head;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                nbits++;
            end else if (busy && nbits > 0) begin
                chk("stall_head_hold", 64'(head), 64'(last_head));
            end
            last_head = head;
            if (done) begin
                ndone++;
                chk("done_after_last_bit", 64'(prev_en), 64'(1));
                chk("busy_at_done", 64'(busy), 64'(0));
                fin = 1;
            end
            prev_en = en;

            if (v.abort_at > 0 && nbits == v.abort_at) begin
                rst_n = 1'b0; valid = 1'b0;
                @(negedge clk);
                chk("abort_busy", 64'(busy), 64'(0));
                chk("abort_en", 64'(en), 64'(0));
                chk("abort_ready", 64'(ready), 64'(0));
                chk("abort_tail_ones", 64'(tail_ones), 64'(0));
                chk("abort_done", 64'(done), 64'(0));
                rst_n = 1'b1;
                @(negedge clk);
                chk("abort_no_done_after", 64'(done), 64'(0));
                return;
            end

            start = 1'b0;
            if (v.restart_at > 0 && nbits == v.restart_at && !rs_done) begin
                start = 1'b1; rs_done = 1;
            end
            if (nhs == 1 && gap_left > 0) begin
                valid = 1'b0;
                if (ready) gap_left--;
            end else begin
                valid = ($urandom_range(0, 99) >= 32'(v.drop));
            end
            data = (nhs < 4) ? v.words[nhs] : 8'hEE;
            if (valid && ready) nhs++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; valid = 1'b0;

        if (!fin) chk("done_timeout", 64'(0), 64'(1));
        chk("en_cycles", 64'(nbits), 64'(30));
        chk("head_seq", 64'(got), 64'(v.exp_head));
        chk("tail_ones", 64'(tail_ones), 64'(v.exp_tail));
        chk("done_pulses", 64'(ndone), 64'(1));
        chk("handshakes", 64'(nhs), 64'(4));
        if (v.drop == 0) chk("bubbles", 64'(last_en - first_en + 1 - nbits), 64'(v.gap));
        for (int i = 0; i < 30; i++) exp_chain[29 - i] = v.exp_head[i];
        chk("chain_contents", 64'(chain_m), 64'(exp_chain));
        tail_at_done = tail_ones;
        repeat (2) @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("idle_busy_after", 64'(busy), 64'(0));
        chk("tail_ones_hold", 64'(tail_ones), 64'(tail_at_done));
    endtask

    initial begin
        vec_t v;
        bit   q[$];
        int   hs5;
        int   nb5;
        int   nd5;
        logic [4:0] got5;

        clk = 1'b0; rst_n = 1'b0; start = 1'b0; valid = 1'b0; data = '0;
        pre_req = 1'b0; pre_val = '0;
        s5_start = 1'b0; s5_valid = 1'b0; s5_data = '0; s5_tail = 1'b1;
        n_vec = 0; n_err = 0;

        tbl[0] = mk({8'h12, 8'hFF, 8'h3C, 8'hA5}, 0, 1, 30'h2AAAAAAA, 30'h12FF3CA5, 15, 0, 0, 0);
        tbl[1] = mk({8'h12, 8'hFF, 8'h3C, 8'hA5}, 5, 1, 30'h3FFFFFFF, 30'h12FF3CA5, 30, 0, 0, 0);
        tbl[2] = mk({8'h00, 8'h00, 8'h00, 8'h00}, 0, 1, 30'h2AAAAAAA, 30'h00000000, 15, 0, 0, 0);
        tbl[3] = mk({8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 30'h0,        30'h00000000, 0,  0, 0, 0);
        tbl[4] = mk({8'h12, 8'hFF, 8'h3C, 8'hA5}, 0, 1, 30'h155,      30'h12FF3CA5, 5,  0, 10, 3);
        tbl[5] = mk({8'h12, 8'hFF, 8'h3C, 8'hA5}, 0, 1, 30'h3FFFFFFF, 30'h12FF3CA5, 30, 12, 0, 0);
        tbl[6] = mk({8'hFF, 8'h00, 8'hC3, 8'h5A}, 0, 1, 30'h0000000F, 30'h3F00C35A, 4,  0, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_head", 64'(head), 64'(0));
        chk("rst_en", 64'(en), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_tail_ones", 64'(tail_ones), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) do_load(tbl[i]);

        // Randomised loads: expected stream is the words' bits LSB-first, cut at the chain length.
        for (int r = 0; r < 16; r++) begin
            for (int w = 0; w < 4; w++) v.words[w] = 8'($urandom);
            v.gap = $urandom_range(0, 3);
            v.drop = (r < 8) ? 0 : 30;
            v.preload = 1; v.pre = 30'($urandom);
            v.abort_at = 0; v.restart_at = 0; v.idle_valid = 0;
            q = {};
            for (int w = 0; w < 4; w++)
                for (int b = 0; b < 8; b++) q.push_back(v.words[w][b]);
            for (int i = 0; i < 30; i++) v.exp_head[i] = q[i];
            v.exp_tail = $countones(v.pre);
            do_load(v);
        end

        // Five-flop chain: one word only, with valid left high throughout.
        hs5 = 0; nb5 = 0; nd5 = 0; got5 = '0;
        s5_data = 8'hF3; s5_valid = 1'b1; s5_start = 1'b1;
        @(negedge clk);
        s5_start = 1'b0;
        for (int c = 0; c < 40 && nd5 == 0; c++) begin
            if (s5_en) begin
                if (nb5 < 5) got5[nb5] = s5_head;
                nb5++;
            end
            if (s5_done) nd5++;
            if (s5_valid && s5_ready) hs5++;
            @(negedge clk);
        end
        s5_valid = 1'b0;
        chk("short_handshakes", 64'(hs5), 64'(1));
        chk("short_en_cycles", 64'(nb5), 64'(5));
        chk("short_head_seq", 64'(got5), 64'(5'b10011));
        chk("short_done", 64'(nd5), 64'(1));
        chk("short_tail_ones", 64'(s5_tail_ones), 64'(5));
        chk("short_busy_after", 64'(s5_busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
